// File: rtl/pid_secuencial.sv
// Sequential discrete PID controller: one sample per Inicio pulse, one shared
// multiplier stepped through the P, I and D products by a small FSM.
module pid_secuencial #(
  parameter int W    = 12,
  parameter int GW   = 16,
  parameter int FRAC = 8,
  parameter int IW   = 16
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Inicio,
  input  logic [1:0]           Modo,
  input  logic signed [W-1:0]  r,
  input  logic signed [W-1:0]  y,
  input  logic signed [GW-1:0] Kp,
  input  logic signed [GW-1:0] Ki,
  input  logic signed [GW-1:0] Kd,
  output logic signed [W-1:0]  u,
  output logic                 Listo,
  output logic                 Ocupado
);

  localparam int MW = (IW > W + 2) ? IW : W + 2;
  localparam int PW = GW + MW;
  localparam int AW = PW + 2;

  localparam logic signed [AW-1:0] U_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] U_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CARGA, MP, MI, MD, SUMA, SAT} state_t;

  function automatic logic signed [AW-1:0] floor_shift(input logic signed [AW-1:0] v);
    return v >>> FRAC;
  endfunction

  function automatic logic signed [W-1:0] sat_out(input logic signed [AW-1:0] v);
    if (v > U_MAX) return {1'b0, {(W-1){1'b1}}};
    if (v < U_MIN) return {1'b1, {(W-1){1'b0}}};
    return v[W-1:0];
  endfunction

  function automatic logic signed [IW-1:0] sat_int(input logic signed [IW:0] v);
    if (v[IW] != v[IW-1]) return v[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    return v[IW-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            modo_q, modo_d;
  logic signed [W-1:0]   r_q, r_d, y_q, y_d, u_q, u_d;
  logic signed [GW-1:0]  kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [W:0]     e_q, e_d, e_prev_q, e_prev_d;
  logic signed [W+1:0]   de_q, de_d;
  logic signed [IW-1:0]  i_q, i_d;
  logic signed [AW-1:0]  acc_q, acc_d, s_q, s_d;
  logic                  listo_q, listo_d, ocupado_q, ocupado_d;
  logic                  sat_prev_q, sat_prev_d, sat_sign_q, sat_sign_d;

  logic signed [GW-1:0]  mul_a;
  logic signed [MW-1:0]  mul_b;
  logic signed [PW-1:0]  prod;
  logic signed [W:0]     e_new;
  logic signed [W+1:0]   de_new;
  logic signed [IW:0]    i_sum;
  logic                  hold;

  // Terms absent from the latched mode are forced to zero at the multiplier input.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MP: begin
        mul_a = kp_q;
        mul_b = MW'(e_q);
      end
      MI: begin
        mul_a = modo_q[1] ? ki_q : '0;
        mul_b = MW'(i_q);
      end
      MD: begin
        mul_a = modo_q[0] ? kd_q : '0;
        mul_b = MW'(de_q);
      end
      default: ;
    endcase
  end

  assign prod = mul_a * mul_b;

  always_comb begin
    state_d    = state_q;
    modo_d     = modo_q;
    r_d        = r_q;
    y_d        = y_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    kd_d       = kd_q;
    e_d        = e_q;
    de_d       = de_q;
    i_d        = i_q;
    e_prev_d   = e_prev_q;
    acc_d      = acc_q;
    s_d        = s_q;
    u_d        = u_q;
    sat_prev_d = sat_prev_q;
    sat_sign_d = sat_sign_q;
    listo_d    = 1'b0;
    ocupado_d  = (state_q == IDLE) ? Inicio : 1'b1;

    e_new  = {r_q[W-1], r_q} - {y_q[W-1], y_q};
    de_new = {e_new[W], e_new} - {e_prev_q[W], e_prev_q};
    i_sum  = {i_q[IW-1], i_q} + {{(IW-W){e_new[W]}}, e_new};
    // Anti-windup: stop integrating while the error still pushes into the last clamp.
    hold   = sat_prev_q && (e_new != '0) && (e_new[W] == sat_sign_q);

    case (state_q)
      IDLE: begin
        if (Inicio) begin
          modo_d  = Modo;
          r_d     = r;
          y_d     = y;
          kp_d    = Kp;
          ki_d    = Ki;
          kd_d    = Kd;
          state_d = CARGA;
        end
      end
      CARGA: begin
        e_d  = e_new;
        de_d = de_new;
        if (!modo_q[1])  i_d = '0;
        else if (!hold)  i_d = sat_int(i_sum);
        state_d = MP;
      end
      MP: begin
        acc_d   = AW'(prod);
        state_d = MI;
      end
      MI: begin
        acc_d   = acc_q + AW'(prod);
        state_d = MD;
      end
      MD: begin
        acc_d   = acc_q + AW'(prod);
        state_d = SUMA;
      end
      SUMA: begin
        s_d     = floor_shift(acc_q);
        state_d = SAT;
      end
      SAT: begin
        u_d        = sat_out(s_q);
        sat_prev_d = (s_q > U_MAX) || (s_q < U_MIN);
        sat_sign_d = s_q[AW-1];
        e_prev_d   = e_q;
        listo_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      u_q        <= '0;
      i_q        <= '0;
      e_prev_q   <= '0;
      sat_prev_q <= 1'b0;
      sat_sign_q <= 1'b0;
      listo_q    <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      u_q        <= u_d;
      i_q        <= i_d;
      e_prev_q   <= e_prev_d;
      sat_prev_q <= sat_prev_d;
      sat_sign_q <= sat_sign_d;
      listo_q    <= listo_d;
      ocupado_q  <= ocupado_d;
    end
  end

  // Operand and intermediate registers carry no reset; control decides when they matter.
  always_ff @(posedge CLK) begin
    modo_q <= modo_d;
    r_q    <= r_d;
    y_q    <= y_d;
    kp_q   <= kp_d;
    ki_q   <= ki_d;
    kd_q   <= kd_d;
    e_q    <= e_d;
    de_q   <= de_d;
    acc_q  <= acc_d;
    s_q    <= s_d;
  end

  assign u       = u_q;
  assign Listo   = listo_q;
  assign Ocupado = ocupado_q;

endmodule

// File: tb/tb_pid_secuencial.sv
// Bench for pid_secuencial: table of samples with expected u fed through a
// scoreboard queue, plus a hand-written reset-abort sequence.
module tb_pid_secuencial;

  localparam int W    = 12;
  localparam int GW   = 16;
  localparam int FRAC = 8;
  localparam int IW   = 16;

  logic                 CLK;
  logic                 Reset;
  logic                 Inicio;
  logic [1:0]           Modo;
  logic signed [W-1:0]  r, y, u;
  logic signed [GW-1:0] Kp, Ki, Kd;
  logic                 Listo, Ocupado;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    bit       rst;
    bit [1:0] modo;
    int       r;
    int       y;
    int       kp;
    int       ki;
    int       kd;
    int       exp_u;
    bit       poke;
  } vec_t;

  vec_t vecs[19];

  pid_secuencial #(.W(W), .GW(GW), .FRAC(FRAC), .IW(IW)) dut (
    .CLK(CLK), .Reset(Reset), .Inicio(Inicio), .Modo(Modo),
    .r(r), .y(y), .Kp(Kp), .Ki(Ki), .Kd(Kd),
    .u(u), .Listo(Listo), .Ocupado(Ocupado)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard: every Listo pops one expected u.
  always @(negedge CLK) begin
    if (Listo === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_listo: got Listo=1 with u=%0d, expected no completion (t=%0t)", u, $time);
      end else begin
        check("u", int'(u), exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    Reset  = 1'b1;
    Inicio = 1'b0;
    @(negedge CLK);
    check("rst_u", int'(u), 0);
    check("rst_listo", int'(Listo), 0);
    check("rst_ocupado", int'(Ocupado), 0);
    Reset = 1'b0;
  endtask

  task automatic run_sample(input vec_t v);
    int  lat;
    int  occ;
    bit  seen;
    exp_q.push_back(v.exp_u);
    @(negedge CLK);
    Modo   = v.modo;
    r      = W'(v.r);
    y      = W'(v.y);
    Kp     = GW'(v.kp);
    Ki     = GW'(v.ki);
    Kd     = GW'(v.kd);
    Inicio = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Inicio = 1'b0;
    // Operands are latched; scramble the inputs to prove it.
    Modo = 2'($urandom);
    r    = W'($urandom);
    y    = W'($urandom);
    Kp   = GW'($urandom);
    Ki   = GW'($urandom);
    Kd   = GW'($urandom);
    check("ocupado_start", int'(Ocupado), 1);
    occ  = 1;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 15 && !seen; k++) begin
      @(negedge CLK);
      if (v.poke && k == 2) Inicio = 1'b1;
      if (v.poke && k == 3) Inicio = 1'b0;
      if (Ocupado) occ++;
      if (Listo) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("listo_seen", int'(seen), 1);
    check("latency", lat, 6);
    check("ocupado_cycles", occ, 7);
    @(negedge CLK);
    check("listo_width", int'(Listo), 0);
    check("ocupado_end", int'(Ocupado), 0);
    @(negedge CLK);
    check("u_hold", int'(u), v.exp_u);
  endtask

  initial begin
    int      listo_cnt;
    vec_t    pid_v;
    Reset  = 1'b1;
    Inicio = 1'b0;
    Modo   = 2'b00;
    r      = '0;
    y      = '0;
    Kp     = '0;
    Ki     = '0;
    Kd     = '0;

    //            rst  modo    r      y     kp    ki   kd   exp    poke
    vecs[0]  = '{1'b1, 2'b00,   100,   40,  256,   0,   0,    60, 1'b0};
    vecs[1]  = '{1'b0, 2'b00,  2047, -2048, 512,   0,   0,  2047, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, -2048,  2047, 512,   0,   0, -2048, 1'b0};
    vecs[3]  = '{1'b0, 2'b00,     0,     3, 384,   0,   0,    -5, 1'b0};
    vecs[4]  = '{1'b0, 2'b00,     5,     0, -256,  0,   0,    -5, 1'b0};
    vecs[5]  = '{1'b1, 2'b01,    10,     0,    0,  0, 256,    10, 1'b0};
    vecs[6]  = '{1'b0, 2'b01,    20,    10,    0,  0, 256,     0, 1'b1};
    vecs[7]  = '{1'b0, 2'b01,     4,     0,    0,  0, 256,    -6, 1'b0};
    vecs[8]  = '{1'b1, 2'b10,     4,     0,    0, 128,  0,     2, 1'b0};
    vecs[9]  = '{1'b0, 2'b10,     4,     0,    0, 128,  0,     4, 1'b0};
    vecs[10] = '{1'b0, 2'b10,     4,     0,    0, 128,  0,     6, 1'b0};
    vecs[11] = '{1'b0, 2'b00,     4,     0,    0, 128,  0,     0, 1'b0};
    vecs[12] = '{1'b0, 2'b10,     4,     0,    0, 128,  0,     2, 1'b0};
    vecs[13] = '{1'b1, 2'b10,  2047,     0,    0, 256,  0,  2047, 1'b0};
    vecs[14] = '{1'b0, 2'b10,  2047,     0,    0, 256,  0,  2047, 1'b0};
    vecs[15] = '{1'b0, 2'b10,  2047,     0,    0, 256,  0,  2047, 1'b0};
    vecs[16] = '{1'b0, 2'b10, -2048,   952,    0, 256,  0,  1094, 1'b0};
    vecs[17] = '{1'b1, 2'b11,    10,     0,  256, 256, 256,   30, 1'b0};
    vecs[18] = '{1'b0, 2'b11,    10,     0,  256, 256, 256,   30, 1'b0};

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].rst) do_reset();
      run_sample(vecs[i]);
    end

    // Reset during MI aborts the sample and clears u, I and e_prev.
    pid_v = '{1'b1, 2'b11, 5, 0, 0, 256, 256, 10, 1'b0};
    do_reset();
    run_sample(pid_v);
    @(negedge CLK);
    Modo   = 2'b11;
    r      = W'(5);
    y      = '0;
    Kp     = '0;
    Ki     = GW'(256);
    Kd     = GW'(256);
    Inicio = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Inicio = 1'b0;
    @(negedge CLK);
    Inicio = 1'b1;
    @(negedge CLK);
    Inicio = 1'b0;
    Reset  = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    check("abort_u", int'(u), 0);
    check("abort_ocupado", int'(Ocupado), 0);
    listo_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (Listo) listo_cnt++;
    end
    check("abort_no_listo", listo_cnt, 0);
    check("abort_u_idle", int'(u), 0);
    run_sample(pid_v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
